// File: rtl/hopn_pipe.sv
// N-hop valid-qualified register pipeline with per-stage clears, global stall,
// a selectable tap, occupancy tracking and a saturating count of cleared tokens.
module hopn_pipe #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clock0,
  input  logic              rst1,
  input  logic [DEPTH-1:0]  stage_clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  start,
  input  logic              in_valid,
  output logic [WIDTH-1:0]  ff_out,
  output logic              out_valid,
  input  logic [3:0]        tap_sel,
  output logic [WIDTH-1:0]  tap_data,
  output logic              tap_valid,
  output logic              tap_err,
  output logic [4:0]        occ,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [DROP_W+4:0] DROP_MAX = {5'b0, {DROP_W{1'b1}}};

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [4:0]        b);
    logic [DROP_W+4:0] sum;
    sum = {5'b0, a} + {{DROP_W{1'b0}}, b};
    if (sum > DROP_MAX) sat_add = DROP_MAX[DROP_W-1:0];
    else                sat_add = sum[DROP_W-1:0];
  endfunction

  function automatic logic [4:0] popcount(input logic [DEPTH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [WIDTH-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0]  v_q, v_d;
  logic [4:0]        occ_q, occ_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [WIDTH-1:0]  prev_data [DEPTH];
  logic [DEPTH-1:0]  prev_v;
  logic [4:0]        ndrop;

  // Source of each stage on an advance: start/in_valid for stage 0, the
  // pre-edge upstream stage otherwise.
  always_comb begin
    prev_data    = '{default: '0};
    prev_v       = '0;
    prev_data[0] = start;
    prev_v[0]    = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      prev_data[i] = data_q[i-1];
      prev_v[i]    = v_q[i-1];
    end
  end

  // A cleared stage drops whatever token would have occupied it after the edge.
  always_comb begin
    data_d = data_q;
    v_d    = v_q;
    ndrop  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_clr[i]) begin
        data_d[i] = '0;
        v_d[i]    = 1'b0;
        if (en ? prev_v[i] : v_q[i]) ndrop = ndrop + 5'd1;
      end else if (en) begin
        data_d[i] = prev_data[i];
        v_d[i]    = prev_v[i];
      end
    end
    occ_d  = popcount(v_d);
    drop_d = sat_add(drop_q, ndrop);
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      v_q    <= '0;
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      v_q    <= v_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    tap_err   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == 4'(i)) begin
        tap_data  = data_q[i];
        tap_valid = v_q[i];
        tap_err   = 1'b0;
      end
    end
  end

  assign ff_out    = data_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];
  assign occ       = occ_q;
  assign drop_cnt  = drop_q;

endmodule
